// File: rtl/vga_fb_pkg.sv
// rtl/vga_fb_pkg.sv - frame-buffer geometry and read-owner tag shared by display and processing paths
package vga_fb_pkg;
    localparam int H_VIS          = 640;
    localparam int V_VIS          = 480;
    localparam int WORDS_PER_LINE = H_VIS / 2;
    localparam int FB_WORDS       = V_VIS * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        DISP = 2'd1,
        PROC = 2'd2
    } owner_t;
endpackage

// File: rtl/vga_fb_pixel_unpack.sv
// rtl/vga_fb_pixel_unpack.sv - splits each fetched 16-bit word into two 8-bit pixels
module vga_fb_pixel_unpack (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [15:0] word_i,
    input  logic        vis_i,
    input  logic        hodd_i,
    output logic [7:0]  pix_data_o,
    output logic        pix_valid_o
);
    logic [15:0] word_q;
    logic [1:0]  vis_q;
    logic [1:0]  hodd_q;

    // vis and Hcnt parity travel two stages so byte select lines up with the fetched word
    always_ff @(posedge clk) begin
        if (!reset) begin
            word_q <= '0;
            vis_q  <= '0;
            hodd_q <= '0;
        end else begin
            if (load_i) begin
                word_q <= word_i;
            end
            vis_q  <= {vis_q[0], vis_i};
            hodd_q <= {hodd_q[0], hodd_i};
        end
    end

    assign pix_valid_o = reset && vis_q[1];
    assign pix_data_o  = !pix_valid_o ? 8'd0 : (hodd_q[1] ? word_q[15:8] : word_q[7:0]);
endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - shares one frame-buffer SRAM between display fetch and a processing requester
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W          = 18,
    parameter bit PROC_BLANK_ONLY = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        Hcnt,
    input  logic [9:0]        Vcnt,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              gnt,
    output logic              rvalid,
    output logic [15:0]       rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata
);
    localparam logic [9:0]        H_VIS_C    = 10'(H_VIS);
    localparam logic [9:0]        V_VIS_C    = 10'(V_VIS);
    localparam logic [ADDR_W-1:0] FB_WORDS_C = ADDR_W'(FB_WORDS);

    logic              vis;
    logic              disp_slot;
    logic              free_slot;
    logic              in_range;
    logic [ADDR_W-1:0] v_ext;
    logic [ADDR_W-1:0] disp_addr;
    owner_t            tag_d, tag_q;
    logic              oor_d, oor_q;

    assign vis       = (Hcnt < H_VIS_C) && (Vcnt < V_VIS_C);
    assign disp_slot = vis && !Hcnt[0];
    assign free_slot = !disp_slot && !(PROC_BLANK_ONLY && vis);
    assign in_range  = req_addr < FB_WORDS_C;

    // Vcnt*320 as two shifts keeps the line base free of a multiplier
    assign v_ext     = ADDR_W'(Vcnt);
    assign disp_addr = (v_ext << 8) + (v_ext << 6) + ADDR_W'(Hcnt[9:1]);

    assign gnt       = reset && free_slot && req;
    assign mem_en    = reset && (disp_slot || (gnt && in_range));
    assign mem_we    = gnt && req_we;
    assign mem_addr  = !reset ? '0 : (disp_slot ? disp_addr : (gnt ? req_addr : '0));
    assign mem_wdata = gnt ? req_wdata : 16'd0;

    always_comb begin
        tag_d = NONE;
        oor_d = 1'b0;
        if (reset && disp_slot) begin
            tag_d = DISP;
        end else if (gnt && !req_we) begin
            tag_d = PROC;
            oor_d = !in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_q <= NONE;
            oor_q <= 1'b0;
        end else begin
            tag_q <= tag_d;
            oor_q <= oor_d;
        end
    end

    // an out-of-range read never touched the SRAM, so it returns zero instead of stale mem_rdata
    assign rvalid = reset && (tag_q == PROC);
    assign rdata  = (rvalid && !oor_q) ? mem_rdata : 16'd0;

    vga_fb_pixel_unpack u_unpack (
        .clk         (clk),
        .reset       (reset),
        .load_i      (tag_q == DISP),
        .word_i      (mem_rdata),
        .vis_i       (vis),
        .hodd_i      (Hcnt[0]),
        .pix_data_o  (pix_data),
        .pix_valid_o (pix_valid)
    );
endmodule
